// File: rtl/jtkcpu_opfetch.sv
// jtkcpu_opfetch: opcode/operand fetch stage feeding the microcode sequencer.
// Owns the PC, reads bytes at PC and stalls the sequencer until each fetch lands.
module jtkcpu_opfetch #(
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        ni,
  input  logic        opd,
  input  logic        memhi,
  input  logic        pc_jmp,
  input  logic [15:0] pc_in,
  input  logic [7:0]  bus_din,
  input  logic        bus_busy,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic [15:0] pc,
  output logic [7:0]  op,
  output logic [15:0] mdata,
  output logic        mem_busy
);
  localparam logic [1:0] IDLE = 2'd0, OPC = 2'd1, OPD1 = 2'd2, OPD2 = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d, mdata_q, mdata_d;
  logic [7:0]  op_q, op_d;
  logic        fetching, take;
  assign fetching = state_q != IDLE;
  assign take     = cen & fetching & ~bus_busy;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    mdata_d = mdata_q;
    if (cen & ~fetching) state_d = ni ? OPC : memhi ? OPD2 : opd ? OPD1 : IDLE;
    if (take) begin
      state_d = state_q == OPD2 ? OPD1 : IDLE;
      pc_d    = pc_q + 16'd1;
      if (state_q == OPC) op_d = bus_din;
      else mdata_d = {mdata_q[7:0], bus_din};
    end
    // a jump overrides the increment of a byte captured on the same edge
    if (cen & pc_jmp) pc_d = pc_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      op_q    <= 8'h00;
      mdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      mdata_q <= mdata_d;
    end
  end
  assign bus_rd   = fetching;
  assign bus_addr = pc_q;
  assign pc       = pc_q;
  assign op       = op_q;
  assign mdata    = mdata_q;
  assign mem_busy = rst_n & (fetching | opd | memhi);
`ifndef SYNTHESIS
  // the sequencer is stalled by mem_busy, so a strobe mid-fetch means a microcode bug
  a_no_req_in_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    !(cen && fetching && (ni || opd || memhi)))
    else $warning("jtkcpu_opfetch: request ignored while a fetch is in progress");
`endif
endmodule

// File: tb/tb_jtkcpu_opfetch.sv
// tb_jtkcpu_opfetch: directed scoreboard bench; each fetch pushes its expected
// op/mdata/pc/read-cycle count, and a monitor checks them when bus_rd falls.
module tb_jtkcpu_opfetch;
  logic        clk = 0, rst_n = 0, cen = 1;
  logic        ni = 0, opd = 0, memhi = 0, pc_jmp = 0;
  logic [15:0] pc_in = 0;
  logic [7:0]  bus_din;
  logic        bus_busy;
  logic [15:0] bus_addr, pc, mdata;
  logic        bus_rd, mem_busy;
  logic [7:0]  op;
  logic [7:0]  mem [0:65535];
  logic [15:0] wait_addr = 0;
  int          wait_cfg = 0, busy_cnt;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] mdata;
    logic [15:0] pc;
    int          cyc;
  } exp_t;
  exp_t q[$];

  jtkcpu_opfetch #(.PC_RST(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ni(ni), .opd(opd), .memhi(memhi),
    .pc_jmp(pc_jmp), .pc_in(pc_in), .bus_din(bus_din), .bus_busy(bus_busy),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .pc(pc), .op(op), .mdata(mdata),
    .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  assign bus_din  = mem[bus_addr];
  assign bus_busy = bus_rd && bus_addr == wait_addr && busy_cnt < wait_cfg;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (!bus_busy) busy_cnt <= 0;
    else if (cen) busy_cnt <= busy_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic n, input logic h, input logic d, input logic j,
                       input logic [15:0] tgt);
    ni = n; memhi = h; opd = d; pc_jmp = j; pc_in = tgt;
    #1;
    chk("mem_busy_on_strobe", {31'd0, mem_busy}, {31'd0, h | d});
    tick;
    ni = 0; memhi = 0; opd = 0; pc_jmp = 0;
  endtask

  task automatic jump(input logic [15:0] tgt);
    pc_jmp = 1; pc_in = tgt;
    tick;
    pc_jmp = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (mem_busy && n < 50) begin
      tick;
      n++;
    end
    chk("fetch_done_in_budget", {31'd0, mem_busy}, 32'd0);
  endtask

  // monitor: a fetch completes when bus_rd falls outside reset
  initial begin
    logic rd_prev = 0;
    int   cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_prev = 0;
        cyc = 0;
      end else begin
        if (bus_rd && cen) cyc++;
        if (rd_prev && !bus_rd) begin
          if (q.size() == 0) begin
            chk("unexpected_fetch_end", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("op", {24'd0, op}, {24'd0, e.op});
            chk("mdata", {16'd0, mdata}, {16'd0, e.mdata});
            chk("pc", {16'd0, pc}, {16'd0, e.pc});
            chk("rd_cycles", cyc, e.cyc);
          end
          cyc = 0;
        end
        rd_prev = bus_rd;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    mem[16'h8000] = 8'h86;
    mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h12;
    mem[16'hFFFF] = 8'h55;
    mem[16'h4000] = 8'h3C;
    mem[16'h7000] = 8'h11; mem[16'h7001] = 8'h22;
    mem[16'h5000] = 8'hA1; mem[16'h2000] = 8'hB2;
    mem[16'h6000] = 8'h77; mem[16'h6001] = 8'h88;
    #12 rst_n = 1;
    tick;
    chk("rst_pc", {16'd0, pc}, 32'h8000);
    chk("rst_op", {24'd0, op}, 32'h0);
    chk("rst_mdata", {16'd0, mdata}, 32'h0);
    chk("rst_bus_rd", {31'd0, bus_rd}, 32'd0);
    chk("rst_mem_busy", {31'd0, mem_busy}, 32'd0);

    // opcode fetch from reset vector, no wait
    q.push_back('{8'h86, 16'h0000, 16'h8001, 1});
    fetch(1, 0, 0, 0, 16'h0);
    chk("ni_bus_rd", {31'd0, bus_rd}, 32'd1);
    chk("ni_bus_addr", {16'd0, bus_addr}, 32'h8000);
    wait_idle;

    // two-byte operand with two wait cycles on the first byte
    jump(16'h1234);
    wait_addr = 16'h1234; wait_cfg = 2;
    q.push_back('{8'h86, 16'hABCD, 16'h1236, 4});
    fetch(0, 1, 0, 0, 16'h0);
    repeat (4) begin
      chk("memhi_stall", {31'd0, mem_busy}, 32'd1);
      tick;
    end
    chk("memhi_stall_release", {31'd0, mem_busy}, 32'd0);
    wait_cfg = 0;

    // preload mdata=0012 then single operand at FFFF wraps the PC
    q.push_back('{8'h86, 16'h0012, 16'h3002, 2});
    fetch(0, 1, 0, 1, 16'h3000);
    wait_idle;
    jump(16'hFFFF);
    q.push_back('{8'h86, 16'h1255, 16'h0000, 1});
    fetch(0, 0, 1, 0, 16'h0);
    wait_idle;

    // jump plus ni on the same edge fetches from the new PC
    q.push_back('{8'h3C, 16'h1255, 16'h4001, 1});
    fetch(1, 0, 0, 1, 16'h4000);
    chk("jmp_ni_addr", {16'd0, bus_addr}, 32'h4000);
    wait_idle;

    // cen low mid-fetch holds everything
    q.push_back('{8'h3C, 16'h1122, 16'h7002, 2});
    fetch(0, 1, 0, 1, 16'h7000);
    cen = 0;
    repeat (3) tick;
    chk("cen_hold_pc", {16'd0, pc}, 32'h7000);
    chk("cen_hold_rd", {31'd0, bus_rd}, 32'd1);
    cen = 1;
    wait_idle;

    // jump on the capture edge of a waited OPD2 byte
    wait_addr = 16'h5000; wait_cfg = 2;
    q.push_back('{8'h3C, 16'hA1B2, 16'h2001, 4});
    fetch(0, 1, 0, 1, 16'h5000);
    repeat (2) tick;
    jump(16'h2000);
    chk("jmp_mid_pc", {16'd0, pc}, 32'h2000);
    chk("jmp_mid_addr", {16'd0, bus_addr}, 32'h2000);
    wait_idle;

    // asynchronous reset in the middle of a stalled OPD2 with cen low
    wait_addr = 16'h6000; wait_cfg = 5;
    fetch(0, 1, 0, 1, 16'h6000);
    tick;
    cen = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_bus_rd", {31'd0, bus_rd}, 32'd0);
    chk("arst_mem_busy", {31'd0, mem_busy}, 32'd0);
    chk("arst_mdata", {16'd0, mdata}, 32'h0);
    chk("arst_pc", {16'd0, pc}, 32'h8000);
    chk("arst_op", {24'd0, op}, 32'h0);
    wait_cfg = 0;
    repeat (2) tick;
    rst_n = 1;
    cen = 1;
    repeat (2) tick;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
